comma_aligner: RTL

- Word aligner directly upstream of the 8b/10b decoder in the RX path.
- Takes unaligned 10-bit words from the deserializer and searches for the comma pattern (from K28.1/K28.5/K28.7) at every bit offset.
- Locks onto a consistent offset and presents byte-aligned 10-bit code groups to the decoder.
- Uses the decoder's decode_error as feedback to detect loss of alignment.

---
 rtl/rx_align_pkg.sv | 31 +++
 rtl/comma_aligner_search.sv | 29 ++
 rtl/comma_aligner.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rx_align_pkg.sv
// Shared types and constants for the RX word aligner.
// The optional loss-of-lock counter in comma_aligner is enabled by
// defining COMMA_ALIGNER_LOSS_CNT_EN.
package rx_align_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  // 7-bit comma prefix (abcdeif) of K28.1/K28.5/K28.7, both disparities
  localparam logic [6:0] COMMA_NEG   = 7'h7C;
  localparam logic [6:0] COMMA_POS   = 7'h03;
  localparam logic [9:0] K28_5_NEG   = 10'h17C;

  localparam int OFFSET_W    = 4;
  localparam int NUM_OFFSETS = 10;
  localparam int WIN_W       = 20;
  localparam int CNT_W       = 3;

  function automatic logic isComma(input logic [6:0] grp);
    return (grp == COMMA_NEG) || (grp == COMMA_POS);
  endfunction

  // Saturating increment: counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/comma_aligner_search.sv
// Combinational comma search over the 20-bit window at all ten bit offsets.
// The lowest matching offset wins.
import rx_align_pkg::*;

module comma_search (
  input  logic [WIN_W-1:0]    window,
  output logic                found,
  output logic [OFFSET_W-1:0] offset
);

  logic [NUM_OFFSETS-1:0] hit;

  for (genvar o = 0; o < NUM_OFFSETS; o++) begin : g_off
    assign hit[o] = isComma(window[o+6:o]);
  end

  // Priority encode, scanning high to low so the lowest hit is the last write
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int o = NUM_OFFSETS - 1; o >= 0; o--) begin
      if (hit[o]) begin
        found  = 1'b1;
        offset = OFFSET_W'(o);
      end
    end
  end

endmodule

// File: rtl/comma_aligner.sv
// Comma-based word aligner in front of the 8b/10b decoder.
// Hunts for a comma at any bit offset, confirms LOCK_COMMAS commas at the
// same offset, then holds that offset until LOSS_ERRORS consecutive
// decoder errors are reported.
// Optional: define COMMA_ALIGNER_LOSS_CNT_EN to add the LossCnt output
// counting LOCKED->HUNT transitions.
import rx_align_pkg::*;

module comma_aligner #(
  parameter int LOCK_COMMAS = 3,
  parameter int LOSS_ERRORS = 4
) (
  input  logic                BitCLK_10,
  input  logic                Reset,
  input  logic [9:0]          RxRaw_10,
  input  logic                decode_error,
  output logic [9:0]          RxAligned_10,
  output logic                Aligned,
  output logic                CommaDet,
  output logic [OFFSET_W-1:0] AlignOffset
`ifdef COMMA_ALIGNER_LOSS_CNT_EN
  ,
  output logic [7:0]          LossCnt
`endif
);

  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_COMMAS);
  localparam logic [CNT_W-1:0] LOSS_C = CNT_W'(LOSS_ERRORS);

  align_state_t        state, stateN;
  logic [9:0]          prevRaw;
  logic [OFFSET_W-1:0] offReg, offN, selOff, foundOff;
  logic [CNT_W-1:0]    commaCnt, commaCntN, errCnt, errCntN;
  logic                found, latchedHit;
  logic [WIN_W-1:0]    window, latchedSh, selSh;

  // Earlier bits sit at lower indices: previous word below, current above
  assign window = {RxRaw_10, prevRaw};

  comma_search u_search (
    .window (window),
    .found  (found),
    .offset (foundOff)
  );

  assign latchedSh  = window >> offReg;
  assign latchedHit = isComma(latchedSh[6:0]);

  // Output offset: a comma just found while hunting/syncing is emitted aligned
  always_comb begin
    selOff = offReg;
    if (state == HUNT && found)
      selOff = foundOff;
    else if (state == SYNC && found && !latchedHit)
      selOff = foundOff;
  end

  assign selSh = window >> selOff;

  // Next-state and counter updates
  always_comb begin
    stateN    = state;
    offN      = offReg;
    commaCntN = commaCnt;
    errCntN   = errCnt;
    case (state)
      HUNT: begin
        if (found) begin
          offN      = foundOff;
          commaCntN = CNT_W'(1);
          stateN    = SYNC;
        end
      end
      SYNC: begin
        // A decoder error outranks any comma seen in the same word
        if (decode_error) begin
          stateN    = HUNT;
          commaCntN = '0;
        end else if (latchedHit) begin
          commaCntN = satInc(commaCnt);
          if (commaCntN >= LOCK_C) begin
            stateN  = LOCKED;
            errCntN = '0;
          end
        end else if (found) begin
          offN      = foundOff;
          commaCntN = CNT_W'(1);
        end
      end
      LOCKED: begin
        if (decode_error) begin
          errCntN = satInc(errCnt);
          if (errCntN >= LOSS_C) begin
            stateN    = HUNT;
            commaCntN = '0;
            errCntN   = '0;
          end
        end else begin
          errCntN = '0;
        end
      end
      default: begin
        stateN    = HUNT;
        commaCntN = '0;
        errCntN   = '0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge BitCLK_10 or posedge Reset) begin
    if (Reset) state <= HUNT;
    else       state <= stateN;
  end

  // Offset, counters and the previous-word register
  always_ff @(posedge BitCLK_10 or posedge Reset) begin
    if (Reset) begin
      prevRaw  <= '0;
      offReg   <= '0;
      commaCnt <= '0;
      errCnt   <= '0;
    end else begin
      prevRaw  <= RxRaw_10;
      offReg   <= offN;
      commaCnt <= commaCntN;
      errCnt   <= errCntN;
    end
  end

  // Registered aligned output, comma flag and lock indication
  always_ff @(posedge BitCLK_10 or posedge Reset) begin
    if (Reset) begin
      RxAligned_10 <= '0;
      CommaDet     <= 1'b0;
      Aligned      <= 1'b0;
    end else begin
      RxAligned_10 <= selSh[9:0];
      CommaDet     <= isComma(selSh[6:0]);
      Aligned      <= (stateN == LOCKED);
    end
  end

  assign AlignOffset = offReg;

`ifdef COMMA_ALIGNER_LOSS_CNT_EN
  // Count lock losses, saturating at all-ones
  always_ff @(posedge BitCLK_10 or posedge Reset) begin
    if (Reset)
      LossCnt <= '0;
    else if (state == LOCKED && stateN == HUNT && LossCnt != 8'hFF)
      LossCnt <= LossCnt + 8'd1;
  end
`endif

endmodule
